// File: rtl/aes_ahb_ctrl_if.sv
// AHB-Lite signal bundle between the decoder/interconnect and the AES controller.
interface aes_ahb_ctrl_if;
   logic        HSEL_1;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [1:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL_1, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL_1, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/aes_ahb_ctrl.sv
// AHB-Lite front end for the byte-serial AES core: buffers key/data, streams
// them into the core, collects the 16 result bytes and reports status/irq.
//
// state  | meaning
// S_IDLE | not busy, waiting for a START write
// S_LOAD | presenting key bytes 0..15 then data bytes 16..31, one per cycle
// S_KICK | one-cycle core_start pulse
// S_WAIT | collecting result bytes, timeout counter running
module aes_ahb_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       HCLK,
   input  logic       HRESET,
   aes_ahb_ctrl_if.slave bus,
   output logic       irq,
   output logic [7:0] core_din,
   output logic       core_din_valid,
   output logic       core_key_sel,
   output logic       core_start,
   input  logic [7:0] core_dout,
   input  logic       core_dout_valid
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_ERR1 = 2'd1;
   localparam logic [1:0] RESP_ERR2 = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT} state_t;

   state_t             state;
   logic [4:0]         cnt;
   logic [3:0]         rcnt;
   logic [TW-1:0]      tcnt;
   logic [3:0][31:0]   key_q;
   logic [3:0][31:0]   din_q;
   logic [3:0][31:0]   dout_q;
   logic               irq_en;
   logic               done;
   logic               err;

   logic [1:0]         resp_q;
   logic               dp_valid;
   logic               dp_write;
   logic [3:0]         dp_addr;

   logic               busy;
   logic               accept;
   logic [3:0]         ap_addr;
   logic               ap_err;
   logic               wr_en;
   logic               start_wr;
   logic [31:0]        rdata;
   logic [4:0]         nxt_idx;
   logic [255:0]       stream;
   logic [255:0]       stream_sh;
   logic [7:0]         ld_byte;
   logic               unused_bits;

   assign unused_bits = ^{bus.HADDR[31:6], bus.HADDR[1:0], bus.HTRANS[0]};

   assign busy     = (state != S_IDLE);
   assign ap_addr  = bus.HADDR[5:2];
   // No new address phase is taken while the first ERROR cycle is stalling the bus.
   assign accept   = bus.HSEL_1 & bus.HTRANS[1] & bus.HREADY & (resp_q != RESP_ERR1);
   assign wr_en    = dp_valid & dp_write;
   assign start_wr = wr_en & (dp_addr == 4'h0) & bus.HWDATA[0] & ~busy;

   // A START committing right now makes the block busy from the next cycle on,
   // so a buffer write arriving behind it must already be refused.
   assign ap_err = (bus.HSIZE != 2'b10) |
                   (bus.HWRITE & ((ap_addr[3:2] == 2'b11) |
                                  ((ap_addr[3:2] != 2'b00) & (busy | start_wr))));

   assign bus.HREADYOUT = (resp_q != RESP_ERR1);
   assign bus.HRESP     = (resp_q != RESP_NONE);
   assign bus.HRDATA    = (dp_valid & ~dp_write) ? rdata : 32'h0;

   assign irq = irq_en & (done | err);

   // Stream byte selection: index 0 is KEY0[31:24], index 31 is DIN3[7:0].
   assign nxt_idx   = (state == S_IDLE) ? 5'd0 : cnt + 5'd1;
   assign stream    = {key_q[0], key_q[1], key_q[2], key_q[3],
                       din_q[0], din_q[1], din_q[2], din_q[3]};
   assign stream_sh = stream << {nxt_idx, 3'b000};
   assign ld_byte   = stream_sh[255:248];

   // Register read mux for the data phase.
   always_comb begin
      rdata = 32'h0;
      case (dp_addr[3:2])
         2'b00: begin
            if (dp_addr[1:0] == 2'd0)      rdata = {30'h0, irq_en, 1'b0};
            else if (dp_addr[1:0] == 2'd1) rdata = {29'h0, err, done, busy};
         end
         2'b01:   rdata = key_q[dp_addr[1:0]];
         2'b10:   rdata = din_q[dp_addr[1:0]];
         default: rdata = dout_q[dp_addr[1:0]];
      endcase
   end

   // Address-phase capture and two-cycle ERROR response sequencing.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         resp_q   <= RESP_NONE;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 4'h0;
      end else begin
         dp_valid <= accept & ~ap_err;
         dp_write <= bus.HWRITE;
         dp_addr  <= ap_addr;
         if (accept & ap_err)        resp_q <= RESP_ERR1;
         else if (resp_q == RESP_ERR1) resp_q <= RESP_ERR2;
         else                        resp_q <= RESP_NONE;
      end
   end

   // Register commits and the sequencing FSM; hardware sets of DONE/ERR come
   // after the W1C decode so they take priority in the same cycle.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state          <= S_IDLE;
         cnt            <= 5'd0;
         rcnt           <= 4'd0;
         tcnt           <= '0;
         key_q          <= '0;
         din_q          <= '0;
         dout_q         <= '0;
         irq_en         <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         core_din       <= 8'h0;
         core_din_valid <= 1'b0;
         core_key_sel   <= 1'b0;
         core_start     <= 1'b0;
      end else begin
         core_start <= 1'b0;

         if (wr_en) begin
            case (dp_addr[3:2])
               2'b00: begin
                  if (dp_addr[1:0] == 2'd0) irq_en <= bus.HWDATA[1];
                  else if (dp_addr[1:0] == 2'd1) begin
                     if (bus.HWDATA[1]) done <= 1'b0;
                     if (bus.HWDATA[2]) err  <= 1'b0;
                  end
               end
               2'b01:   key_q[dp_addr[1:0]] <= bus.HWDATA;
               2'b10:   din_q[dp_addr[1:0]] <= bus.HWDATA;
               default: ;
            endcase
         end

         case (state)
            S_IDLE: begin
               if (start_wr) begin
                  state          <= S_LOAD;
                  done           <= 1'b0;
                  err            <= 1'b0;
                  cnt            <= 5'd0;
                  core_din       <= ld_byte;
                  core_din_valid <= 1'b1;
                  core_key_sel   <= 1'b1;
               end
            end
            S_LOAD: begin
               if (cnt == 5'd31) begin
                  state          <= S_KICK;
                  core_din       <= 8'h0;
                  core_din_valid <= 1'b0;
                  core_key_sel   <= 1'b0;
                  core_start     <= 1'b1;
               end else begin
                  cnt          <= cnt + 5'd1;
                  core_din     <= ld_byte;
                  core_key_sel <= ~nxt_idx[4];
               end
            end
            S_KICK: begin
               state <= S_WAIT;
               rcnt  <= 4'd0;
               tcnt  <= '0;
            end
            S_WAIT: begin
               if (core_dout_valid) begin
                  dout_q[rcnt[3:2]][{~rcnt[1:0], 3'b000} +: 8] <= core_dout;
                  rcnt <= rcnt + 4'd1;
               end
               if (core_dout_valid && rcnt == 4'd15) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ahb_ctrl.sv
// Directed bench for aes_ahb_ctrl: bus transfers, byte stream order, result
// capture, busy/size errors, timeout, W1C race and mid-operation reset.
module tb_aes_ahb_ctrl;
   logic       HCLK = 1'b0;
   logic       HRESET;
   logic       irq;
   logic [7:0] core_din;
   logic       core_din_valid;
   logic       core_key_sel;
   logic       core_start;
   logic [7:0] core_dout;
   logic       core_dout_valid;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 HCLK = ~HCLK;

   aes_ahb_ctrl_if bus ();
   assign bus.HREADY = bus.HREADYOUT;

   aes_ahb_ctrl #(.TIMEOUT_CYCLES(20)) dut (
      .HCLK            (HCLK),
      .HRESET          (HRESET),
      .bus             (bus),
      .irq             (irq),
      .core_din        (core_din),
      .core_din_valid  (core_din_valid),
      .core_key_sel    (core_key_sel),
      .core_start      (core_start),
      .core_dout       (core_dout),
      .core_dout_valid (core_dout_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic ahb_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic exp_err);
      bus.HSEL_1 = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = {24'h0, a};
      bus.HWRITE = 1'b1; bus.HSIZE = sz;
      tick();
      bus.HSEL_1 = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 2'b10;
      bus.HWDATA = d;
      @(negedge HCLK);
      chk({tag, " hresp"}, 32'(bus.HRESP), 32'(exp_err));
      if (exp_err) begin
         chk({tag, " hreadyout c1"}, 32'(bus.HREADYOUT), 32'd0);
         tick();
         @(negedge HCLK);
         chk({tag, " hresp c2"}, 32'(bus.HRESP), 32'd1);
         chk({tag, " hreadyout c2"}, 32'(bus.HREADYOUT), 32'd1);
      end
      tick();
   endtask

   task automatic ahb_rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_v);
      bus.HSEL_1 = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = {24'h0, a};
      bus.HWRITE = 1'b0; bus.HSIZE = 2'b10;
      tick();
      bus.HSEL_1 = 1'b0; bus.HTRANS = 2'b00;
      @(negedge HCLK);
      chk(tag, bus.HRDATA, exp_v);
      tick();
   endtask

   task automatic core_ret(input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         core_dout       = base + 8'(k);
         core_dout_valid = 1'b1;
         tick();
      end
      core_dout_valid = 1'b0;
      core_dout       = 8'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] eb;
      bus.HSEL_1 = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HSIZE = 2'b10; bus.HWDATA = 32'h0;
      core_dout = 8'h0; core_dout_valid = 1'b0;
      HRESET = 1'b1;
      repeat (3) tick();
      @(negedge HCLK);
      chk("rst hreadyout", 32'(bus.HREADYOUT), 32'd1);
      chk("rst hresp", 32'(bus.HRESP), 32'd0);
      chk("rst hrdata", bus.HRDATA, 32'h0);
      chk("rst irq", 32'(irq), 32'd0);
      chk("rst core_din_valid", 32'(core_din_valid), 32'd0);
      HRESET = 1'b0;
      tick();
      ahb_rd_chk("rst status", 8'h04, 32'h0);

      // Full operation
      ahb_wr("wr key0", 8'h10, 32'h00010203, 2'b10, 1'b0);
      ahb_wr("wr key1", 8'h14, 32'h04050607, 2'b10, 1'b0);
      ahb_wr("wr key2", 8'h18, 32'h08090A0B, 2'b10, 1'b0);
      ahb_wr("wr key3", 8'h1C, 32'h0C0D0E0F, 2'b10, 1'b0);
      ahb_wr("wr din0", 8'h20, 32'h00112233, 2'b10, 1'b0);
      ahb_wr("wr din1", 8'h24, 32'h44556677, 2'b10, 1'b0);
      ahb_wr("wr din2", 8'h28, 32'h8899AABB, 2'b10, 1'b0);
      ahb_wr("wr din3", 8'h2C, 32'hCCDDEEFF, 2'b10, 1'b0);
      ahb_rd_chk("rd key1", 8'h14, 32'h04050607);
      ahb_rd_chk("rd din2", 8'h28, 32'h8899AABB);
      ahb_wr("start op1", 8'h00, 32'h3, 2'b10, 1'b0);
      for (int i = 0; i < 32; i++) begin
         eb = (i < 16) ? 8'(i) : 8'((i - 16) * 17);
         @(negedge HCLK);
         chk($sformatf("load valid %0d", i), 32'(core_din_valid), 32'd1);
         chk($sformatf("load byte %0d", i), 32'(core_din), 32'(eb));
         chk($sformatf("load keysel %0d", i), 32'(core_key_sel), (i < 16) ? 32'd1 : 32'd0);
         chk($sformatf("load nostart %0d", i), 32'(core_start), 32'd0);
         tick();
      end
      @(negedge HCLK);
      chk("kick start", 32'(core_start), 32'd1);
      chk("kick valid", 32'(core_din_valid), 32'd0);
      tick();
      @(negedge HCLK);
      chk("wait start low", 32'(core_start), 32'd0);
      core_ret(16, 8'h80);
      @(negedge HCLK);
      chk("op1 irq", 32'(irq), 32'd1);
      ahb_rd_chk("op1 status", 8'h04, 32'h2);
      ahb_rd_chk("op1 dout0", 8'h30, 32'h80818283);
      ahb_rd_chk("op1 dout3", 8'h3C, 32'h8C8D8E8F);
      ahb_rd_chk("op1 ctrl", 8'h00, 32'h2);
      ahb_rd_chk("unmapped 0x08", 8'h08, 32'h0);

      // Illegal size and DOUT write
      ahb_wr("byte wr din0", 8'h20, 32'hDEADBEEF, 2'b00, 1'b1);
      ahb_rd_chk("din0 kept", 8'h20, 32'h00112233);
      ahb_wr("wr dout1", 8'h34, 32'hDEADBEEF, 2'b10, 1'b1);
      ahb_rd_chk("dout1 kept", 8'h34, 32'h84858687);

      // W1C of DONE
      ahb_wr("w1c done", 8'h04, 32'h2, 2'b10, 1'b0);
      ahb_rd_chk("status cleared", 8'h04, 32'h0);
      @(negedge HCLK);
      chk("irq cleared", 32'(irq), 32'd0);
      tick();

      // Timeout with busy guard
      ahb_wr("start op2", 8'h00, 32'h3, 2'b10, 1'b0);
      repeat (32) tick();
      @(negedge HCLK);
      chk("op2 kick", 32'(core_start), 32'd1);
      tick();
      core_ret(3, 8'hA0);
      ahb_wr("busy wr key1", 8'h14, 32'hFFFFFFFF, 2'b10, 1'b1);
      ahb_wr("start while busy", 8'h00, 32'h3, 2'b10, 1'b0);
      ahb_rd_chk("op2 busy", 8'h04, 32'h1);
      repeat (9) tick();
      @(negedge HCLK);
      chk("irq before timeout", 32'(irq), 32'd0);
      tick();
      @(negedge HCLK);
      chk("irq at timeout", 32'(irq), 32'd1);
      tick();
      ahb_rd_chk("op2 status err", 8'h04, 32'h4);
      ahb_rd_chk("op2 dout0 partial", 8'h30, 32'hA0A1A283);
      ahb_rd_chk("key1 unchanged", 8'h14, 32'h04050607);

      // W1C racing the 16th result byte
      ahb_wr("start op3", 8'h00, 32'h1, 2'b10, 1'b0);
      repeat (32) tick();
      tick();
      core_ret(15, 8'h10);
      bus.HSEL_1 = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h04;
      bus.HWRITE = 1'b1; bus.HSIZE = 2'b10;
      tick();
      bus.HSEL_1 = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HWDATA = 32'h2;
      core_dout = 8'h1F; core_dout_valid = 1'b1;
      @(negedge HCLK);
      chk("race hresp", 32'(bus.HRESP), 32'd0);
      tick();
      core_dout_valid = 1'b0; core_dout = 8'h0;
      ahb_rd_chk("race done wins", 8'h04, 32'h2);
      ahb_rd_chk("op3 dout3", 8'h3C, 32'h1C1D1E1F);
      ahb_wr("w1c after race", 8'h04, 32'h2, 2'b10, 1'b0);
      ahb_rd_chk("done cleared", 8'h04, 32'h0);

      // Reset in the middle of LOAD
      ahb_wr("start op4", 8'h00, 32'h1, 2'b10, 1'b0);
      repeat (5) tick();
      @(negedge HCLK);
      chk("op4 loading", 32'(core_din_valid), 32'd1);
      HRESET = 1'b1;
      tick();
      @(negedge HCLK);
      chk("midrst valid", 32'(core_din_valid), 32'd0);
      chk("midrst din", 32'(core_din), 32'd0);
      chk("midrst keysel", 32'(core_key_sel), 32'd0);
      tick();
      HRESET = 1'b0;
      @(negedge HCLK);
      chk("midrst hreadyout", 32'(bus.HREADYOUT), 32'd1);
      chk("midrst hresp", 32'(bus.HRESP), 32'd0);
      chk("midrst start", 32'(core_start), 32'd0);
      chk("midrst irq", 32'(irq), 32'd0);
      tick();
      repeat (40) begin
         @(negedge HCLK);
         if (core_din_valid !== 1'b0 || core_start !== 1'b0)
            chk("post-rst core idle", {30'h0, core_din_valid, core_start}, 32'h0);
         tick();
      end
      ahb_rd_chk("midrst status", 8'h04, 32'h0);
      ahb_rd_chk("midrst key0", 8'h10, 32'h0);
      ahb_rd_chk("midrst dout0", 8'h30, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
